tick_monitor: RTL

//  Consumer end of the periodic tick interface: watches the 1-cycle tick pulse from the countdown

---
 rtl/tick_monitor_if.sv | 36 +++
 rtl/tick_monitor.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/tick_monitor_if.sv
//------------------------------------------------------------------------------
// Module   : tick_monitor_if
// Purpose  : Bundles the tick_monitor control input, tick pulse and status
//            outputs into one interface.
// Ports    : enable, tick_in         -- driven by the master (system side)
//            period, period_valid,
//            early, missing,
//            fault_count, fault      -- driven by the slave (tick_monitor)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tick_monitor_if #(
  parameter int CNT_W = 28
);
  logic             enable;
  logic             tick_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             early;
  logic             missing;
  logic [7:0]       fault_count;
  logic             fault;

  modport master (
    output enable, tick_in,
    input  period, period_valid, early, missing, fault_count, fault
  );

  modport slave (
    input  enable, tick_in,
    output period, period_valid, early, missing, fault_count, fault
  );
endinterface

`default_nettype wire

// File: rtl/tick_monitor.sv
//------------------------------------------------------------------------------
// Module   : tick_monitor
// Purpose  : Measures the clk-cycle interval between consecutive 1-cycle tick
//            pulses, flags early and missing ticks and keeps a saturating
//            fault count.
// Ports    : clk    -- system clock, all logic on posedge
//            rst_n  -- asynchronous active-low reset
//            mon    -- tick_monitor_if.slave:
//                      enable, tick_in (in); period, period_valid, early,
//                      missing, fault_count, fault (out, all registered)
// Config   : TICK_MON_STICKY_EN -- when defined, fault latches on the first
//            early/missing event until enable=0 or reset; otherwise fault
//            pulses for one cycle per event.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_monitor #(
  parameter int EXPECT_PERIOD = 50000000,
  parameter int TOLERANCE     = 1000,
  parameter int CNT_W         = 28
) (
  input  logic           clk,
  input  logic           rst_n,
  tick_monitor_if.slave  mon
);

  // Last count value before the window closes; a tick-free edge here is a timeout.
  localparam logic [CNT_W-1:0] c_last_cnt  = CNT_W'(EXPECT_PERIOD + TOLERANCE - 1);
  // Measured intervals strictly below this are early.
  localparam logic [CNT_W-1:0] c_early_lim = CNT_W'(EXPECT_PERIOD - TOLERANCE);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FIRST = 2'd1,
    S_MEASURE    = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_period_valid;
  logic             r_early;
  logic             r_missing;
  logic [7:0]       r_fault_count;
  logic             r_fault;

  logic [CNT_W-1:0] w_m;
  logic             w_tick_meas;
  logic             w_early_evt;
  logic             w_missing_evt;
  logic             w_fault_evt;

  // Interval ending at this edge: cnt counts edges since the previous tick, minus one.
  assign w_m           = r_cnt + CNT_W'(1);
  assign w_tick_meas   = (r_state == S_MEASURE) && mon.tick_in;
  assign w_early_evt   = w_tick_meas && (w_m < c_early_lim);
  // A tick on the timeout edge takes priority, so missing needs tick_in low.
  assign w_missing_evt = (r_state == S_MEASURE) && !mon.tick_in && (r_cnt == c_last_cnt);
  assign w_fault_evt   = mon.enable && (w_early_evt || w_missing_evt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_early        <= 1'b0;
      r_missing      <= 1'b0;
      r_fault_count  <= 8'd0;
      r_fault        <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      r_early        <= 1'b0;
      r_missing      <= 1'b0;

      if (!mon.enable) begin
        r_state       <= S_IDLE;
        r_cnt         <= '0;
        r_period      <= '0;
        r_fault_count <= 8'd0;
        r_fault       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_WAIT_FIRST;
          end

          // The first tick only establishes phase; there is no interval yet.
          S_WAIT_FIRST: begin
            if (mon.tick_in) begin
              r_state <= S_MEASURE;
              r_cnt   <= '0;
            end
          end

          S_MEASURE: begin
            if (mon.tick_in) begin
              r_period       <= w_m;
              r_period_valid <= 1'b1;
              r_early        <= w_early_evt;
              r_cnt          <= '0;
            end else if (r_cnt == c_last_cnt) begin
              // Window closed without a tick: report and resynchronise.
              r_missing <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_WAIT_FIRST;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase

        if (w_fault_evt && (r_fault_count != 8'hFF)) begin
          r_fault_count <= r_fault_count + 8'd1;
        end

`ifdef TICK_MON_STICKY_EN
        if (w_fault_evt) begin
          r_fault <= 1'b1;
        end
`else
        r_fault <= w_fault_evt;
`endif
      end
    end
  end

  assign mon.period       = r_period;
  assign mon.period_valid = r_period_valid;
  assign mon.early        = r_early;
  assign mon.missing      = r_missing;
  assign mon.fault_count  = r_fault_count;
  assign mon.fault        = r_fault;

endmodule

`default_nettype wire
